or_stream_accum: RTL

OR_STREAM_ACCUM -- requirements
Module: or_stream_accum

---
 rtl/or_stream_accum.sv | 80 ++++++++
 1 files changed

// File: rtl/or_stream_accum.sv
// Packet OR-accumulator: ORs every accepted word of a packet together, counts the
// beats (saturating) and presents the result with a valid/ready handshake.
module or_stream_accum #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_nz,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             xfer;
  logic [WIDTH-1:0] acc_nx;
  logic [CNT_W-1:0] cnt_nx;

  // Ready depends only on state and clear so upstream can never form a loop through it.
  assign in_ready = (state == ACCUM) && !clear;
  assign xfer     = in_valid && in_ready;
  assign acc_nx   = acc | in_data;
  assign cnt_nx   = (count == CNT_MAX) ? count : count + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_nz    <= 1'b0;
      out_count <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (clear) begin
            acc   <= '0;
            count <= '0;
          end else if (xfer) begin
            if (in_last) begin
              out_data  <= acc_nx;
              out_nz    <= |acc_nx;
              out_count <= cnt_nx;
              out_valid <= 1'b1;
              state     <= HOLD;
              acc       <= '0;
              count     <= '0;
            end else begin
              acc   <= acc_nx;
              count <= cnt_nx;
            end
          end
        end
        HOLD: begin
          // Result registers stay put after the handshake until the next packet ends.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
